display_source_mux_n: RTL and testbench

Parametrised N-source display selector. It sits between the image-processing pipeline (RGB, gray, histogram, threshold stages) and the SDRAM write ports that feed the touch-panel TCON. It latches a one-hot source select only during a qualified vertical blank, and muxes the selected source's pixel, valid and highlight signals. It packs the result into the two 16-bit TCON write words, and reports the valid-pixel count of each frame.

---
 rtl/display_pkg.sv | 35 +++
 rtl/fval_blank_timer.sv | 42 ++++
 rtl/display_source_mux_n.sv | 206 ++++++++++++++++++++
 tb/tb_display_source_mux_n.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared constants and helpers for the display source selector:
//   RED_R        - highlight / error red level
//   TCON_W       - width of one TCON write word
//   pack_tcon    - packs 8-bit R/G/B into the two TCON words {wr1, wr2}
//   onehot_legal - 1 when a select vector (up to 16 bits) has exactly one bit set
// -----------------------------------------------------------------------------
package display_pkg;

   localparam logic [7:0] RED_R  = 8'hFF;
   localparam int         TCON_W = 16;

   // wr1 = {0, G[7:3], B[7:0], 00}; wr2 = {0, G[2:0], 00, R[7:0], 00}
   function automatic logic [2*TCON_W-1:0] pack_tcon(input logic [7:0] r,
                                                     input logic [7:0] g,
                                                     input logic [7:0] b);
      logic [TCON_W-1:0] wr1;
      logic [TCON_W-1:0] wr2;
      wr1 = {1'b0, g[7:3], b, 2'b00};
      wr2 = {1'b0, g[2:0], 2'b00, r, 2'b00};
      return {wr1, wr2};
   endfunction

   // Popcount == 1 over a zero-extended 16-bit vector
   function automatic logic onehot_legal(input logic [15:0] vec);
      logic [4:0] cnt;
      cnt = 5'd0;
      for (int i = 0; i < 16; i++) begin
         cnt = cnt + {4'd0, vec[i]};
      end
      return (cnt == 5'd1);
   endfunction

endpackage

// File: rtl/fval_blank_timer.sv
// -----------------------------------------------------------------------------
// fval_blank_timer
// Counts consecutive low cycles of the registered frame-valid and issues a
// single-cycle load pulse once the blank has lasted BLANK_CYCLES cycles.
// The counter saturates, so only one pulse is produced per blank period.
// Ports:
//   iClk    - pixel clock
//   iRst_n  - asynchronous active-low reset
//   iFval_r - registered frame valid
//   oLoad   - one-cycle select load pulse
// -----------------------------------------------------------------------------
module fval_blank_timer #(
   parameter int BLANK_CYCLES = 50
) (
   input  logic iClk,
   input  logic iRst_n,
   input  logic iFval_r,
   output logic oLoad
);

   localparam logic [7:0] L_BLANK   = 8'(BLANK_CYCLES);
   localparam logic [7:0] L_LOAD_AT = 8'(BLANK_CYCLES - 1);

   logic [7:0] r_cnt;

   // Saturating blank-length counter, cleared whenever a frame is active
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_cnt <= 8'd0;
      end else if (iFval_r) begin
         r_cnt <= 8'd0;
      end else if (r_cnt < L_BLANK) begin
         r_cnt <= r_cnt + 8'd1;
      end else begin
         r_cnt <= r_cnt;
      end
   end

   // The saturating count passes L_LOAD_AT only once per blank
   assign oLoad = ~iFval_r & (r_cnt == L_LOAD_AT);

endmodule

// File: rtl/display_source_mux_n.sv
// -----------------------------------------------------------------------------
// display_source_mux_n
// N-source display selector between the image pipeline and the TCON SDRAM
// write ports. The one-hot source select is only latched after a qualified
// vertical blank. The chosen source is muxed, with mono expansion and a red
// highlight. The pixel is packed into two 16-bit TCON words, and the
// valid-pixel count of each frame is reported.
// Ports:
//   iClk, iRst_n             - pixel clock, async active-low reset
//   iFval                    - camera frame valid
//   iSelect                  - one-hot source request
//   iSrc_R/G/B               - packed per-source channels, source i at [i*PIX_W +: PIX_W]
//   iSrc_valid, iSrc_red     - per-source pixel valid and highlight flags
//   oWr1_data, oWr2_data     - packed TCON words
//   oWr_data_valid           - write strobe for both words
//   oActive_src              - latched select (0 in error mode)
//   oSel_error               - latched select was not one-hot
//   oFrame_pixels            - valid-pixel count of the last completed frame
// -----------------------------------------------------------------------------
module display_source_mux_n
   import display_pkg::*;
#(
   parameter int                 NUM_SRC      = 8,
   parameter int                 PIX_W        = 8,
   parameter logic [NUM_SRC-1:0] MONO_MASK    = NUM_SRC'(8'b0000_0010),
   parameter int                 BLANK_CYCLES = 50,
   parameter int                 DEFAULT_SRC  = 0,
   parameter int                 CNT_W        = 24
) (
   input  logic                     iClk,
   input  logic                     iRst_n,
   input  logic                     iFval,
   input  logic [NUM_SRC-1:0]       iSelect,
   input  logic [NUM_SRC*PIX_W-1:0] iSrc_R,
   input  logic [NUM_SRC*PIX_W-1:0] iSrc_G,
   input  logic [NUM_SRC*PIX_W-1:0] iSrc_B,
   input  logic [NUM_SRC-1:0]       iSrc_valid,
   input  logic [NUM_SRC-1:0]       iSrc_red,
   output logic [TCON_W-1:0]        oWr1_data,
   output logic [TCON_W-1:0]        oWr2_data,
   output logic                     oWr_data_valid,
   output logic [NUM_SRC-1:0]       oActive_src,
   output logic                     oSel_error,
   output logic [CNT_W-1:0]         oFrame_pixels
);

   localparam logic [NUM_SRC-1:0] SEL_RST  = NUM_SRC'(1) << DEFAULT_SRC;
   localparam logic [NUM_SRC-1:0] SEL_NONE = {NUM_SRC{1'b0}};
   localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};

   logic                 r_fval;
   logic                 r_fval_d;
   logic [NUM_SRC-1:0]   r_active;
   logic                 r_sel_error;
   logic [TCON_W-1:0]    r_wr1;
   logic [TCON_W-1:0]    r_wr2;
   logic                 r_wr_valid;
   logic [CNT_W-1:0]     r_pix_cnt;
   logic [CNT_W-1:0]     r_frame_pixels;

   logic                 w_load;
   logic                 w_fall;
   logic [15:0]          w_sel_ext;
   logic                 w_sel_legal;
   logic [7:0]           w_sel_r;
   logic [7:0]           w_sel_g;
   logic [7:0]           w_sel_b;
   logic                 w_sel_valid;
   logic                 w_sel_red;
   logic                 w_sel_mono;
   logic [7:0]           w_r;
   logic [7:0]           w_g;
   logic [7:0]           w_b;
   logic                 w_valid;
   logic [2*TCON_W-1:0]  w_pack;
   logic [CNT_W-1:0]     w_cnt_inc;

   fval_blank_timer #(
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_blank_timer (
      .iClk    (iClk),
      .iRst_n  (iRst_n),
      .iFval_r (r_fval),
      .oLoad   (w_load)
   );

   // Registered frame valid and its one-cycle delay for edge detection
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_fval   <= 1'b0;
         r_fval_d <= 1'b0;
      end else begin
         r_fval   <= iFval;
         r_fval_d <= r_fval;
      end
   end

   assign w_fall = r_fval_d & ~r_fval;

   // Zero-extend the request so the shared 16-bit legality helper can be used
   always_comb begin
      w_sel_ext                = 16'd0;
      w_sel_ext[NUM_SRC-1:0]   = iSelect;
      w_sel_legal              = onehot_legal(w_sel_ext);
   end

   // Select latch: only at the load pulse, an illegal request forces error mode
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_active    <= SEL_RST;
         r_sel_error <= 1'b0;
      end else if (w_load) begin
         r_active    <= w_sel_legal ? iSelect : SEL_NONE;
         r_sel_error <= ~w_sel_legal;
      end else begin
         r_active    <= r_active;
         r_sel_error <= r_sel_error;
      end
   end

   // AND-OR mux of the selected source; the latched select is one-hot or zero
   always_comb begin
      w_sel_r     = 8'd0;
      w_sel_g     = 8'd0;
      w_sel_b     = 8'd0;
      w_sel_valid = 1'b0;
      w_sel_red   = 1'b0;
      w_sel_mono  = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         w_sel_r     = w_sel_r | (iSrc_R[i*PIX_W + PIX_W - 8 +: 8] & {8{r_active[i]}});
         w_sel_g     = w_sel_g | (iSrc_G[i*PIX_W + PIX_W - 8 +: 8] & {8{r_active[i]}});
         w_sel_b     = w_sel_b | (iSrc_B[i*PIX_W + PIX_W - 8 +: 8] & {8{r_active[i]}});
         w_sel_valid = w_sel_valid | (iSrc_valid[i] & r_active[i]);
         w_sel_red   = w_sel_red   | (iSrc_red[i]   & r_active[i]);
         w_sel_mono  = w_sel_mono  | (MONO_MASK[i]  & r_active[i]);
      end
   end

   // Pixel colour selection: error red, blank, highlight, mono or colour
   always_comb begin
      w_r     = 8'd0;
      w_g     = 8'd0;
      w_b     = 8'd0;
      w_valid = 1'b0;
      if (r_active == SEL_NONE) begin
         w_r     = RED_R;
         w_valid = iSrc_valid[0];
      end else if (!w_sel_valid) begin
         w_valid = 1'b0;
      end else if (w_sel_red) begin
         w_r     = RED_R;
         w_valid = 1'b1;
      end else if (w_sel_mono) begin
         w_r     = w_sel_r;
         w_g     = w_sel_r;
         w_b     = w_sel_r;
         w_valid = 1'b1;
      end else begin
         w_r     = w_sel_r;
         w_g     = w_sel_g;
         w_b     = w_sel_b;
         w_valid = 1'b1;
      end
   end

   assign w_pack = pack_tcon(w_r, w_g, w_b);

   // Output pixel register: one cycle from source inputs to TCON words
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_wr1      <= 16'd0;
         r_wr2      <= 16'd0;
         r_wr_valid <= 1'b0;
      end else begin
         r_wr1      <= w_pack[2*TCON_W-1:TCON_W];
         r_wr2      <= w_pack[TCON_W-1:0];
         r_wr_valid <= w_valid;
      end
   end

   // Saturating increment so a stuck-high valid never wraps the count
   assign w_cnt_inc = (r_wr_valid && (r_pix_cnt != CNT_MAX)) ?
                      (r_pix_cnt + CNT_W'(1)) : r_pix_cnt;

   // Frame pixel counter; the capture includes the count of the fall cycle
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_pix_cnt      <= {CNT_W{1'b0}};
         r_frame_pixels <= {CNT_W{1'b0}};
      end else if (w_fall) begin
         r_pix_cnt      <= {CNT_W{1'b0}};
         r_frame_pixels <= w_cnt_inc;
      end else begin
         r_pix_cnt      <= w_cnt_inc;
         r_frame_pixels <= r_frame_pixels;
      end
   end

   assign oWr1_data      = r_wr1;
   assign oWr2_data      = r_wr2;
   assign oWr_data_valid = r_wr_valid;
   assign oActive_src    = r_active;
   assign oSel_error     = r_sel_error;
   assign oFrame_pixels  = r_frame_pixels;

endmodule

// File: tb/tb_display_source_mux_n.sv
// -----------------------------------------------------------------------------
// tb_display_source_mux_n
// Directed bench for display_source_mux_n with default parameters.
// Expected TCON words are hand-packed from wr1 = {0,G[7:3],B,00} and
// wr2 = {0,G[2:0],00,R,00}.
// -----------------------------------------------------------------------------
module tb_display_source_mux_n;

   logic        clk;
   logic        rst_n;
   logic        fval;
   logic [7:0]  sel;
   logic [63:0] src_r;
   logic [63:0] src_g;
   logic [63:0] src_b;
   logic [7:0]  src_valid;
   logic [7:0]  src_red;
   logic [15:0] wr1;
   logic [15:0] wr2;
   logic        wr_valid;
   logic [7:0]  active;
   logic        sel_err;
   logic [23:0] frame_pix;

   int checks;
   int errors;

   display_source_mux_n dut (
      .iClk           (clk),
      .iRst_n         (rst_n),
      .iFval          (fval),
      .iSelect        (sel),
      .iSrc_R         (src_r),
      .iSrc_G         (src_g),
      .iSrc_B         (src_b),
      .iSrc_valid     (src_valid),
      .iSrc_red       (src_red),
      .oWr1_data      (wr1),
      .oWr2_data      (wr2),
      .oWr_data_valid (wr_valid),
      .oActive_src    (active),
      .oSel_error     (sel_err),
      .oFrame_pixels  (frame_pix)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int idx, input logic [7:0] r, input logic [7:0] g,
                          input logic [7:0] b);
      src_r[idx*8 +: 8] = r;
      src_g[idx*8 +: 8] = g;
      src_b[idx*8 +: 8] = b;
   endtask

   // Short frame followed by a blank of blank_len cycles with a new request
   task automatic frame_then_blank(input logic [7:0] req, input int blank_len);
      fval = 1'b1;
      tick(5);
      sel  = req;
      fval = 1'b0;
      tick(blank_len);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      fval      = 1'b0;
      sel       = 8'h04;
      src_r     = 64'd0;
      src_g     = 64'd0;
      src_b     = 64'd0;
      src_valid = 8'h00;
      src_red   = 8'h00;
      tick(3);

      // Reset state
      chk("rst_active", {24'd0, active}, 32'h0000_0001);
      chk("rst_sel_err", {31'd0, sel_err}, 32'd0);
      chk("rst_wr1", {16'd0, wr1}, 32'd0);
      chk("rst_wr2", {16'd0, wr2}, 32'd0);
      chk("rst_valid", {31'd0, wr_valid}, 32'd0);
      chk("rst_frame_pix", {8'd0, frame_pix}, 32'd0);

      // First blank after reset: load exactly on the 50th edge
      rst_n = 1'b1;
      tick(49);
      chk("no_load_at_49", {24'd0, active}, 32'h0000_0001);
      tick(1);
      chk("load_at_50", {24'd0, active}, 32'h0000_0004);
      chk("load_sel_err", {31'd0, sel_err}, 32'd0);

      // Colour source 2: R=12 G=AB B=34
      set_src(2, 8'h12, 8'hAB, 8'h34);
      src_valid = 8'h04;
      tick(1);
      chk("col_wr1", {16'd0, wr1}, 32'h0000_54D0);
      chk("col_wr2", {16'd0, wr2}, 32'h0000_3048);
      chk("col_valid", {31'd0, wr_valid}, 32'd1);
      src_valid = 8'h00;
      tick(1);
      chk("inval_wr2", {16'd0, wr2}, 32'd0);
      chk("inval_valid", {31'd0, wr_valid}, 32'd0);

      // Mono source 1: R=80 replicated, G/B inputs ignored, then highlight
      frame_then_blank(8'h02, 60);
      chk("mono_active", {24'd0, active}, 32'h0000_0002);
      set_src(1, 8'h80, 8'h55, 8'hAA);
      src_valid = 8'h02;
      tick(1);
      chk("mono_wr1", {16'd0, wr1}, 32'h0000_4200);
      chk("mono_wr2", {16'd0, wr2}, 32'h0000_0200);
      chk("mono_valid", {31'd0, wr_valid}, 32'd1);
      src_red = 8'h02;
      tick(1);
      chk("red_wr1", {16'd0, wr1}, 32'h0000_0000);
      chk("red_wr2", {16'd0, wr2}, 32'h0000_03FC);
      chk("red_valid", {31'd0, wr_valid}, 32'd1);
      src_red   = 8'h00;
      src_valid = 8'h00;

      // Illegal request 06: error mode, solid red, valid follows source 0
      frame_then_blank(8'h06, 60);
      chk("err_flag", {31'd0, sel_err}, 32'd1);
      chk("err_active", {24'd0, active}, 32'd0);
      tick(1);
      chk("err_wr2_v0", {16'd0, wr2}, 32'h0000_03FC);
      chk("err_valid0", {31'd0, wr_valid}, 32'd0);
      src_valid = 8'h01;
      tick(1);
      chk("err_wr1_v1", {16'd0, wr1}, 32'd0);
      chk("err_wr2_v1", {16'd0, wr2}, 32'h0000_03FC);
      chk("err_valid1", {31'd0, wr_valid}, 32'd1);
      src_valid = 8'h00;

      // Recover to source 2
      frame_then_blank(8'h04, 60);
      chk("recover_active", {24'd0, active}, 32'h0000_0004);
      chk("recover_err", {31'd0, sel_err}, 32'd0);

      // Mid-frame request change and a short blank must not switch
      fval = 1'b1;
      tick(5);
      sel = 8'h08;
      tick(5);
      chk("midframe_hold", {24'd0, active}, 32'h0000_0004);
      fval = 1'b0;
      tick(30);
      fval = 1'b1;
      tick(5);
      chk("short_blank_hold", {24'd0, active}, 32'h0000_0004);

      // Full blank applies 08; a later request in the same blank is ignored
      fval = 1'b0;
      tick(55);
      chk("long_blank_load", {24'd0, active}, 32'h0000_0008);
      sel = 8'h10;
      tick(5);
      chk("one_load_per_blank", {24'd0, active}, 32'h0000_0008);
      set_src(3, 8'hF0, 8'h0F, 8'hC3);
      src_valid = 8'h08;
      fval = 1'b1;
      tick(1);
      chk("src3_wr1", {16'd0, wr1}, 32'h0000_070C);
      chk("src3_wr2", {16'd0, wr2}, 32'h0000_73C0);

      // Clear the counter with a frame end, then a 640x4 valid-pixel frame
      src_valid = 8'h00;
      tick(2);
      fval = 1'b0;
      tick(5);
      fval = 1'b1;
      tick(3);
      src_valid = 8'h08;
      tick(2560);
      src_valid = 8'h00;
      tick(3);
      fval = 1'b0;
      tick(5);
      chk("frame_pixels", {8'd0, frame_pix}, 32'd2560);

      // Async reset mid-frame clears everything without a clock edge
      fval      = 1'b1;
      src_valid = 8'h08;
      tick(10);
      chk("pre_rst_valid", {31'd0, wr_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_active", {24'd0, active}, 32'h0000_0001);
      chk("arst_wr1", {16'd0, wr1}, 32'd0);
      chk("arst_wr2", {16'd0, wr2}, 32'd0);
      chk("arst_valid", {31'd0, wr_valid}, 32'd0);
      chk("arst_frame_pix", {8'd0, frame_pix}, 32'd0);
      chk("arst_sel_err", {31'd0, sel_err}, 32'd0);

      // After reset the default source 0 drives the output mid-frame
      tick(1);
      rst_n = 1'b1;
      set_src(0, 8'h21, 8'h43, 8'h65);
      src_valid = 8'h01;
      tick(1);
      chk("dflt_active", {24'd0, active}, 32'h0000_0001);
      chk("dflt_wr1", {16'd0, wr1}, 32'h0000_2194);
      chk("dflt_wr2", {16'd0, wr2}, 32'h0000_3084);
      chk("dflt_valid", {31'd0, wr_valid}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
